// File: rtl/instr_encoder_loader.sv
// Program loader: packs symbolic MIPS instruction requests into 32-bit words and writes them to imem.
// Optional macro ENC_ILLEGAL_TRAP_EN: R-type words with unsupported funct are dropped and flag err.
//   state   | meaning
//   IDLE    | ready for a request
//   ENCODE  | captured fields being packed into the write-data register
//   WRITE   | imem_we strobe, pointer advances at the end of the cycle
//   FULL    | DEPTH words written; leaves only on reset or clear
module instr_encoder_loader #(
    parameter int ADDR_W    = 8,
    parameter int DEPTH     = 256,
    parameter int BASE_ADDR = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clear,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        kind,
    input  logic [4:0]        rs,
    input  logic [4:0]        rt,
    input  logic [4:0]        rd,
    input  logic [4:0]        shamt,
    input  logic [5:0]        funct,
    input  logic [15:0]       imm,
    input  logic [25:0]       target,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic [ADDR_W:0]   count,
    output logic              full,
    output logic              err
);

    typedef enum logic [1:0] {S_IDLE, S_ENCODE, S_WRITE, S_FULL} state_t;

    localparam logic [ADDR_W:0]   DEPTH_C = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W-1:0] BASE_C  = ADDR_W'(BASE_ADDR);

    state_t        state_q, state_d;
    logic [ADDR_W:0] ptr_q, ptr_d, ptr_inc;
    logic [31:0]   wdata_q, wdata_d, enc_word;
    logic          err_q, err_d;
    logic          illegal;
    logic          accept;

    logic [2:0]    kind_q;
    logic [4:0]    rs_q, rt_q, rd_q, shamt_q;
    logic [5:0]    funct_q;
    logic [15:0]   imm_q;
    logic [25:0]   target_q;

    assign in_ready = (state_q == S_IDLE) & ~clear & ~reset;
    assign accept   = in_valid & in_ready;
    assign ptr_inc  = ptr_q + 1'b1;

    always_comb begin
        enc_word = 32'h0;
        case (kind_q)
            3'd0:    enc_word = {6'b000000, rs_q, rt_q, rd_q, shamt_q, funct_q};
            3'd1:    enc_word = {6'b100011, rs_q, rt_q, imm_q};
            3'd2:    enc_word = {6'b101011, rs_q, rt_q, imm_q};
            3'd3:    enc_word = {6'b001000, rs_q, rt_q, imm_q};
            3'd4:    enc_word = {6'b001100, rs_q, rt_q, imm_q};
            3'd5:    enc_word = {6'b001101, rs_q, rt_q, imm_q};
            3'd6:    enc_word = {6'b000100, rs_q, rt_q, imm_q};
            default: enc_word = {6'b000010, target_q};
        endcase
    end

`ifdef ENC_ILLEGAL_TRAP_EN
    // Only add/sub/and/or/xor/nor are accepted as R-type function codes.
    assign illegal = (kind_q == 3'd0) &&
                     !(funct_q inside {6'h20, 6'h22, 6'h24, 6'h25, 6'h26, 6'h27});
`else
    assign illegal = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        wdata_d = wdata_q;
        err_d   = err_q;
        case (state_q)
            S_IDLE: begin
                if (accept) state_d = S_ENCODE;
            end
            S_ENCODE: begin
                if (illegal) begin
                    err_d   = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    wdata_d = enc_word;
                    state_d = S_WRITE;
                end
            end
            S_WRITE: begin
                ptr_d   = ptr_inc;
                state_d = (ptr_inc == DEPTH_C) ? S_FULL : S_IDLE;
            end
            default: state_d = S_FULL;
        endcase
        // clear abandons any in-flight word but keeps the sticky error
        if (clear) begin
            state_d = S_IDLE;
            ptr_d   = '0;
            wdata_d = wdata_q;
            err_d   = err_q;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            ptr_q    <= '0;
            wdata_q  <= 32'h0;
            err_q    <= 1'b0;
            kind_q   <= 3'd0;
            rs_q     <= 5'd0;
            rt_q     <= 5'd0;
            rd_q     <= 5'd0;
            shamt_q  <= 5'd0;
            funct_q  <= 6'd0;
            imm_q    <= 16'd0;
            target_q <= 26'd0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            wdata_q <= wdata_d;
            err_q   <= err_d;
            if (accept) begin
                kind_q   <= kind;
                rs_q     <= rs;
                rt_q     <= rt;
                rd_q     <= rd;
                shamt_q  <= shamt;
                funct_q  <= funct;
                imm_q    <= imm;
                target_q <= target;
            end
        end
    end

    assign imem_we    = (state_q == S_WRITE) & ~clear & ~reset;
    assign imem_addr  = BASE_C + ptr_q[ADDR_W-1:0];
    assign imem_wdata = wdata_q;
    assign count      = ptr_q;
    assign full       = (ptr_q == DEPTH_C);
    assign err        = err_q;

endmodule
